coeff_token_dec_chromadc: RTL and testbench

COEFF_TOKEN_DEC_CHROMADC -- requirements
Module: coeff_token_dec_chromadc

---
 rtl/coeff_token_dec_chromadc_if.sv | 28 ++
 rtl/coeff_token_dec_chromadc.sv | 152 +++++++++++++++
 tb/tb_coeff_token_dec_chromadc.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/coeff_token_dec_chromadc_if.sv
// Bit-in / token-out bundle for the chroma DC coeff_token decoder.
// master: bitstream source and token sink; slave: the decoder.
interface coeff_token_dec_chromadc_if #(
    parameter int CNT_W = 16
);
    logic             clr_i;
    logic             bit_i;
    logic             bit_valid_i;
    logic             bit_ready_o;
    logic             tok_valid_o;
    logic             tok_ready_i;
    logic [2:0]       total_coeff_o;
    logic [1:0]       trailing_ones_o;
    logic [3:0]       code_len_o;
    logic [CNT_W-1:0] tok_cnt_o;

    modport master (
        output clr_i, bit_i, bit_valid_i, tok_ready_i,
        input  bit_ready_o, tok_valid_o, total_coeff_o, trailing_ones_o,
               code_len_o, tok_cnt_o
    );

    modport slave (
        input  clr_i, bit_i, bit_valid_i, tok_ready_i,
        output bit_ready_o, tok_valid_o, total_coeff_o, trailing_ones_o,
               code_len_o, tok_cnt_o
    );
endinterface

// File: rtl/coeff_token_dec_chromadc.sv
// H.264 chroma DC (nC = -1) coeff_token decoder.
// Shifts bits MSB-first until a table code completes, then holds the
// decoded {TotalCoeff, TrailingOnes, length} until downstream accepts.
module coeff_token_dec_chromadc #(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    coeff_token_dec_chromadc_if.slave   bus
);
    typedef enum logic {SHIFT, OUT} state_t;

    state_t           state_q, state_d;
    logic [6:0]       sr_q, sr_d;
    logic [3:0]       len_q, len_d;
    logic [2:0]       tc_q, tc_d;
    logic [1:0]       t1_q, t1_d;
    logic [3:0]       cl_q, cl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       cand;
    logic [3:0]       cand_len;
    logic             hit;
    logic [2:0]       hit_tc;
    logic [1:0]       hit_t1;

    // Match the code formed by the held bits plus the incoming bit.
    // Held bits are zero above the current length, so full-width compares are safe.
    always_comb begin
        cand     = {sr_q, bus.bit_i};
        cand_len = len_q + 4'd1;
        hit      = 1'b0;
        hit_tc   = '0;
        hit_t1   = '0;
        unique case (cand_len)
            4'd1: if (cand[0] == 1'b1)         begin hit = 1'b1; hit_tc = 3'd1; hit_t1 = 2'd1; end
            4'd2: if (cand[1:0] == 2'b01)      begin hit = 1'b1; hit_tc = 3'd0; hit_t1 = 2'd0; end
            4'd3: if (cand[2:0] == 3'b001)     begin hit = 1'b1; hit_tc = 3'd2; hit_t1 = 2'd2; end
            4'd6: begin
                hit = 1'b1;
                case (cand[5:0])
                    6'b000111: begin hit_tc = 3'd1; hit_t1 = 2'd0; end
                    6'b000100: begin hit_tc = 3'd2; hit_t1 = 2'd0; end
                    6'b000110: begin hit_tc = 3'd2; hit_t1 = 2'd1; end
                    6'b000011: begin hit_tc = 3'd3; hit_t1 = 2'd0; end
                    6'b000101: begin hit_tc = 3'd3; hit_t1 = 2'd3; end
                    6'b000010: begin hit_tc = 3'd4; hit_t1 = 2'd0; end
                    default:   hit = 1'b0;
                endcase
            end
            4'd7: begin
                hit = 1'b1;
                case (cand[6:0])
                    7'b0000011: begin hit_tc = 3'd3; hit_t1 = 2'd1; end
                    7'b0000010: begin hit_tc = 3'd3; hit_t1 = 2'd2; end
                    7'b0000000: begin hit_tc = 3'd4; hit_t1 = 2'd3; end
                    default:    hit = 1'b0;
                endcase
            end
            4'd8: begin
                hit = 1'b1;
                case (cand)
                    8'b00000011: begin hit_tc = 3'd4; hit_t1 = 2'd1; end
                    8'b00000010: begin hit_tc = 3'd4; hit_t1 = 2'd2; end
                    default:     hit = 1'b0;
                endcase
            end
            default: hit = 1'b0;
        endcase
    end

    // Next-state and datapath updates; clr_i overrides everything except the counter.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        len_d   = len_q;
        tc_d    = tc_q;
        t1_d    = t1_q;
        cl_d    = cl_q;
        cnt_d   = cnt_q;
        if (bus.clr_i) begin
            state_d = SHIFT;
            sr_d    = '0;
            len_d   = '0;
            tc_d    = '0;
            t1_d    = '0;
            cl_d    = '0;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (bus.bit_valid_i) begin
                        if (hit) begin
                            state_d = OUT;
                            sr_d    = '0;
                            len_d   = '0;
                            tc_d    = hit_tc;
                            t1_d    = hit_t1;
                            cl_d    = cand_len;
                        end else begin
                            sr_d    = cand[6:0];
                            len_d   = cand_len;
                        end
                    end
                end
                OUT: begin
                    if (bus.tok_ready_i) begin
                        state_d = SHIFT;
                        tc_d    = '0;
                        t1_d    = '0;
                        cl_d    = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = SHIFT;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SHIFT;
            sr_q    <= '0;
            len_q   <= '0;
            tc_q    <= '0;
            t1_q    <= '0;
            cl_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            tc_q    <= tc_d;
            t1_q    <= t1_d;
            cl_q    <= cl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Token fields are zeroed whenever leaving OUT, so they read 0 while not valid.
    assign bus.bit_ready_o     = (state_q == SHIFT);
    assign bus.tok_valid_o     = (state_q == OUT);
    assign bus.total_coeff_o   = tc_q;
    assign bus.trailing_ones_o = t1_q;
    assign bus.code_len_o      = cl_q;
    assign bus.tok_cnt_o       = cnt_q;

    // The table is prefix-complete: seven held bits plus any eighth bit always match.
    a_len_bound: assert property (@(posedge clk) disable iff (rst) len_q < 4'd8);
    a_eighth_hits: assert property (@(posedge clk) disable iff (rst)
        (state_q == SHIFT && bus.bit_valid_i && !bus.clr_i && len_q == 4'd7) |-> hit);
endmodule

// File: tb/tb_coeff_token_dec_chromadc.sv
// Directed bench for the chroma DC coeff_token decoder.
module tb_coeff_token_dec_chromadc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coeff_token_dec_chromadc_if #(.CNT_W(16)) m ();
    coeff_token_dec_chromadc_if #(.CNT_W(4))  w ();

    // Narrow-counter instance sees exactly the same stimulus.
    assign w.clr_i       = m.clr_i;
    assign w.bit_i       = m.bit_i;
    assign w.bit_valid_i = m.bit_valid_i;
    assign w.tok_ready_i = m.tok_ready_i;

    coeff_token_dec_chromadc #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(m));
    coeff_token_dec_chromadc #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(w));

    typedef struct {
        logic [7:0] code;
        int         len;
        int         tc;
        int         t1;
    } vec_t;

    vec_t tbl [14];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        logic rdy;
        repeat (gap) tick();
        m.bit_i       = b;
        m.bit_valid_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rdy = m.bit_ready_o;
            tick();
            if (rdy) begin
                m.bit_valid_i = 1'b0;
                return;
            end
        end
        m.bit_valid_i = 1'b0;
        chk("bit_accept_timeout", 0, 1);
    endtask

    task automatic send_code(input logic [7:0] code, input int len, input int maxgap);
        for (int i = len - 1; i >= 0; i--)
            send_bit(code[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic expect_tok(input string name, input int tc, input int t1, input int len);
        chk({name, "_valid"}, int'(m.tok_valid_o), 1);
        chk({name, "_ready"}, int'(m.bit_ready_o), 0);
        chk({name, "_tc"},    int'(m.total_coeff_o), tc);
        chk({name, "_t1"},    int'(m.trailing_ones_o), t1);
        chk({name, "_len"},   int'(m.code_len_o), len);
    endtask

    task automatic accept(input string name);
        m.tok_ready_i = 1'b1;
        tick();
        m.tok_ready_i = 1'b0;
        exp_cnt++;
        chk({name, "_acc_valid"},  int'(m.tok_valid_o), 0);
        chk({name, "_acc_ready"},  int'(m.bit_ready_o), 1);
        chk({name, "_acc_fields"}, int'({m.total_coeff_o, m.trailing_ones_o, m.code_len_o}), 0);
        chk({name, "_acc_cnt"},    int'(m.tok_cnt_o), exp_cnt & 16'hFFFF);
    endtask

    task automatic do_reset();
        m.clr_i = 1'b0; m.bit_i = 1'b0; m.bit_valid_i = 1'b0; m.tok_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        tbl[0]  = '{8'b00000001, 1, 1, 1};
        tbl[1]  = '{8'b00000001, 2, 0, 0};
        tbl[2]  = '{8'b00000001, 3, 2, 2};
        tbl[3]  = '{8'b00000111, 6, 1, 0};
        tbl[4]  = '{8'b00000100, 6, 2, 0};
        tbl[5]  = '{8'b00000110, 6, 2, 1};
        tbl[6]  = '{8'b00000011, 6, 3, 0};
        tbl[7]  = '{8'b00000101, 6, 3, 3};
        tbl[8]  = '{8'b00000010, 6, 4, 0};
        tbl[9]  = '{8'b00000011, 7, 3, 1};
        tbl[10] = '{8'b00000010, 7, 3, 2};
        tbl[11] = '{8'b00000000, 7, 4, 3};
        tbl[12] = '{8'b00000011, 8, 4, 1};
        tbl[13] = '{8'b00000010, 8, 4, 2};

        // Reset values while rst is held
        m.clr_i = 1'b0; m.bit_i = 1'b0; m.bit_valid_i = 1'b0; m.tok_ready_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_ready",  int'(m.bit_ready_o), 1);
        chk("rst_valid",  int'(m.tok_valid_o), 0);
        chk("rst_fields", int'({m.total_coeff_o, m.trailing_ones_o, m.code_len_o}), 0);
        chk("rst_cnt",    int'(m.tok_cnt_o), 0);
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt = 0;
        tick();

        // Single-bit code, latency 1
        send_code(8'b1, 1, 0);
        expect_tok("c1", 1, 1, 1);
        accept("c1");

        // Longest code
        send_code(8'b00000010, 8, 0);
        expect_tok("c8", 4, 2, 8);
        accept("c8");

        // Hold with bits offered: nothing consumed, fields stable
        send_code(8'b0, 7, 0);
        expect_tok("c7", 4, 3, 7);
        m.bit_i = 1'b1;
        m.bit_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_tok("hold", 4, 3, 7);
        end
        m.bit_valid_i = 1'b0;
        accept("hold");
        send_code(8'b01, 2, 0);
        expect_tok("c01", 0, 0, 2);
        accept("c01");

        // All codes back-to-back with input gaps and output stalls
        do_reset();
        for (int i = 0; i < 14; i++) begin
            send_code(tbl[i].code, tbl[i].len, 2);
            expect_tok($sformatf("tbl%0d", i), tbl[i].tc, tbl[i].t1, tbl[i].len);
            repeat ($urandom_range(0, 3)) begin
                tick();
                expect_tok($sformatf("tbl%0d_stall", i), tbl[i].tc, tbl[i].t1, tbl[i].len);
            end
            accept($sformatf("tbl%0d", i));
        end
        chk("tbl_cnt14", int'(m.tok_cnt_o), 14);

        // clr_i mid-code drops the partial code and the bit offered with it
        send_code(8'b0001, 4, 0);
        m.clr_i = 1'b1; m.bit_i = 1'b1; m.bit_valid_i = 1'b1;
        tick();
        m.clr_i = 1'b0; m.bit_valid_i = 1'b0;
        chk("clr_ready", int'(m.bit_ready_o), 1);
        send_code(8'b001, 3, 0);
        expect_tok("clr_c3", 2, 2, 3);
        accept("clr_c3");

        // clr_i during hold wins over tok_ready_i; counter untouched
        send_code(8'b1, 1, 0);
        expect_tok("clr_hold", 1, 1, 1);
        m.clr_i = 1'b1; m.tok_ready_i = 1'b1;
        tick();
        m.clr_i = 1'b0; m.tok_ready_i = 1'b0;
        chk("clr_hold_valid",  int'(m.tok_valid_o), 0);
        chk("clr_hold_fields", int'({m.total_coeff_o, m.trailing_ones_o, m.code_len_o}), 0);
        chk("clr_hold_cnt",    int'(m.tok_cnt_o), exp_cnt);

        // Asynchronous reset mid-hold
        send_code(8'b001, 3, 0);
        expect_tok("arst_c3", 2, 2, 3);
        rst = 1'b1;
        #1;
        chk("arst_valid",  int'(m.tok_valid_o), 0);
        chk("arst_ready",  int'(m.bit_ready_o), 1);
        chk("arst_fields", int'({m.total_coeff_o, m.trailing_ones_o, m.code_len_o}), 0);
        chk("arst_cnt",    int'(m.tok_cnt_o), 0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;

        // Counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_code(8'b1, 1, 0);
            accept("wrap");
        end
        chk("wrap_cnt4", int'(w.tok_cnt_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
